// File: rtl/obj_sched_pkg.sv
// Shared types and line-timing constants for the OBJ row scheduler.
package obj_sched_pkg;
    localparam int LINES       = 228;
    localparam int VISIBLE     = 160;
    localparam int BUDGET_FULL = 1210;
    localparam int BUDGET_HBF  = 954;
    localparam int COL_W       = 8;
    localparam int PIX_W       = 20;
    localparam int LINE_W      = 8;
    localparam int BUD_W       = 11;

    typedef enum logic [2:0] {IDLE, CLEAR, GO, RENDER, DONE} state_e;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] data;
        logic             transparent;
        logic             palettemode;
    } pix_t;

    // Line being prepared during H-blank of line v.
    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] v);
        return (v == LINE_W'(LINES - 1)) ? '0 : v + 1'b1;
    endfunction
endpackage

// File: rtl/obj_row_sched_if.sv
// Pixel-engine <-> scheduler link: render start/done plus the valid/ready pixel stream.
interface obj_row_sched_if;
    import obj_sched_pkg::*;

    logic              render_go;
    logic [LINE_W-1:0] target_line;
    logic              render_done;
    logic              px_valid;
    logic              px_ready;
    logic [COL_W-1:0]  px_col;
    logic [PIX_W-1:0]  px_data;
    logic              px_transparent;
    logic              px_palettemode;

    modport master (
        input  render_go, target_line, px_ready,
        output render_done, px_valid, px_col, px_data, px_transparent, px_palettemode
    );
    modport slave (
        output render_go, target_line, px_ready,
        input  render_done, px_valid, px_col, px_data, px_transparent, px_palettemode
    );
endinterface

// File: rtl/obj_cycle_budget.sv
// Per-line render budget: loadable down-counter that saturates at zero.
// Latency: load/dec take effect on the next clock.
// Backpressure: none; the zero flag is what closes the pixel handshake upstream.
module obj_cycle_budget
    import obj_sched_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [BUD_W-1:0] load_val,
    output logic [BUD_W-1:0] value,
    output logic             zero
);
    logic [BUD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);
endmodule

// File: rtl/obj_row_sched.sv
// Per-scanline sequencer: clears the OBJ back buffer, then lets the pixel engine fill it.
// Latency: clear 1 cycle after line_start, render_go after 2; pixel writes land 1 cycle after accept.
// Backpressure: px_ready is high only in RENDER while budget remains; no pixel is ever dropped once accepted.
module obj_row_sched
    import obj_sched_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              line_start,
    input  logic [LINE_W-1:0] vcount,
    input  logic              hblank_free,
    obj_row_sched_if.slave    eng,
    output logic [LINE_W-1:0] row,
    output logic              clear,
    output logic              we,
    output logic [COL_W-1:0]  wcol,
    output logic [PIX_W-1:0]  wdata,
    output logic              transparent,
    output logic              palettemode,
    output logic              overrun
);
    state_e            state_q, state_d;
    logic [LINE_W-1:0] row_q, row_d, tgt_q, tgt_d, t_new;
    logic              hbf_q, hbf_d, clear_q, clear_d, go_q, go_d;
    logic              ovr_q, ovr_d, we_q, we_d;
    pix_t              pix_q, pix_d;
    logic              px_rdy, accept, bud_load, bud_dec, bud_zero;
    logic [BUD_W-1:0]  bud_val, bud_init;

    assign bud_init = hbf_q ? BUD_W'(BUDGET_HBF) : BUD_W'(BUDGET_FULL);
    assign bud_load = (state_q == GO);
    assign bud_dec  = (state_q == RENDER);

    obj_cycle_budget u_budget (
        .clock    (clock),
        .reset    (reset),
        .load     (bud_load),
        .dec      (bud_dec),
        .load_val (bud_init),
        .value    (bud_val),
        .zero     (bud_zero)
    );

    assign px_rdy = (state_q == RENDER) && (bud_val != '0);
    assign accept = eng.px_valid && px_rdy;
    assign t_new  = next_line(vcount);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tgt_d   = tgt_q;
        hbf_d   = hbf_q;
        clear_d = 1'b0;
        go_d    = 1'b0;
        ovr_d   = 1'b0;
        we_d    = accept;
        pix_d   = pix_q;
        if (accept) begin
            pix_d.col         = eng.px_col;
            pix_d.data        = eng.px_data;
            pix_d.transparent = eng.px_transparent;
            pix_d.palettemode = eng.px_palettemode;
        end

        // A new line always wins, even over render_done in the same cycle.
        if (line_start) begin
            tgt_d = t_new;
            hbf_d = hblank_free;
            ovr_d = (state_q inside {CLEAR, GO, RENDER});
            if (t_new < LINE_W'(VISIBLE)) begin
                state_d = CLEAR;
                row_d   = vcount;
                clear_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                CLEAR: begin
                    state_d = GO;
                    row_d   = tgt_q;
                    go_d    = 1'b1;
                end
                GO:     state_d = RENDER;
                RENDER: begin
                    if (eng.render_done) begin
                        state_d = DONE;
                    end else if (bud_zero) begin
                        state_d = DONE;
                        ovr_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            tgt_q   <= '0;
            hbf_q   <= 1'b0;
            clear_q <= 1'b0;
            go_q    <= 1'b0;
            ovr_q   <= 1'b0;
            we_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tgt_q   <= tgt_d;
            hbf_q   <= hbf_d;
            clear_q <= clear_d;
            go_q    <= go_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            pix_q   <= pix_d;
        end
    end

    assign eng.render_go   = go_q;
    assign eng.target_line = tgt_q;
    assign eng.px_ready    = px_rdy;
    assign row             = row_q;
    assign clear           = clear_q;
    assign we              = we_q;
    assign wcol            = pix_q.col;
    assign wdata           = pix_q.data;
    assign transparent     = pix_q.transparent;
    assign palettemode     = pix_q.palettemode;
    assign overrun         = ovr_q;
endmodule

// File: tb/tb_obj_row_sched.sv
// Directed + randomized bench for obj_row_sched with a timestamp-based reference model.
module tb_obj_row_sched;
    logic        clock, reset, line_start, hblank_free;
    logic [7:0]  vcount, row, wcol;
    logic        clear, we, transparent, palettemode, overrun;
    logic [19:0] wdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: everything is timed relative to the cycle of the last line_start.
    int          m_ls  = -1000;
    int          m_b   = 0;
    bit          m_seq = 0;
    bit          m_we  = 0;
    bit          m_ovr = 0;
    bit          m_tr  = 0;
    bit          m_pm  = 0;
    logic [7:0]  m_t   = 0;
    logic [7:0]  m_row = 0;
    logic [7:0]  m_col = 0;
    logic [19:0] m_dat = 0;

    obj_row_sched_if eng();

    obj_row_sched dut (
        .clock       (clock),
        .reset       (reset),
        .line_start  (line_start),
        .vcount      (vcount),
        .hblank_free (hblank_free),
        .eng         (eng),
        .row         (row),
        .clear       (clear),
        .we          (we),
        .wcol        (wcol),
        .wdata       (wdata),
        .transparent (transparent),
        .palettemode (palettemode),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ls = -1000; m_b = 0; m_seq = 0; m_we = 0; m_ovr = 0;
        m_tr = 0; m_pm = 0; m_t = 0; m_row = 0; m_col = 0; m_dat = 0;
    endtask

    task automatic idle_inputs();
        line_start = 0; vcount = 0; hblank_free = 0;
        eng.render_done = 0; eng.px_valid = 0; eng.px_col = 0;
        eng.px_data = 0; eng.px_transparent = 0; eng.px_palettemode = 0;
    endtask

    // Compare this cycle's outputs with the model, advance the model on the inputs, then clock.
    task automatic step();
        bit rdy_e, acc;
        rdy_e = m_seq && (cyc >= m_ls + 3) && (cyc <= m_ls + 2 + m_b);
        chk("clear",       clear,           m_seq && (cyc == m_ls + 1));
        chk("render_go",   eng.render_go,   m_seq && (cyc == m_ls + 2));
        chk("px_ready",    eng.px_ready,    rdy_e);
        chk("row",         row,             m_row);
        chk("target_line", eng.target_line, m_t);
        chk("overrun",     overrun,         m_ovr);
        chk("we",          we,              m_we);
        chk("wcol",        wcol,            m_col);
        chk("wdata",       wdata,           m_dat);
        chk("transparent", transparent,     m_tr);
        chk("palettemode", palettemode,     m_pm);
        if (!reset) begin
            model_reset();
        end else begin
            acc  = eng.px_valid && rdy_e;
            m_we = acc;
            if (acc) begin
                m_col = eng.px_col; m_dat = eng.px_data;
                m_tr  = eng.px_transparent; m_pm = eng.px_palettemode;
            end
            m_ovr = 0;
            if (line_start) begin
                m_ovr = m_seq;
                m_t   = 8'((int'(vcount) + 1) % 228);
                m_b   = hblank_free ? 954 : 1210;
                m_ls  = cyc;
                m_seq = (m_t < 160);
                if (m_seq) m_row = vcount;
            end else if (m_seq) begin
                if (cyc == m_ls + 1) m_row = m_t;
                if (cyc >= m_ls + 3) begin
                    if (eng.render_done) begin
                        m_seq = 0;
                    end else if (cyc == m_ls + 3 + m_b) begin
                        m_seq = 0;
                        m_ovr = 1;
                    end
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic ls(input logic [7:0] v, input logic h);
        line_start = 1; vcount = v; hblank_free = h;
        step();
        line_start = 0;
    endtask

    task automatic pix(input logic [7:0] c, input logic [19:0] d, input logic t, input logic p);
        eng.px_valid = 1; eng.px_col = c; eng.px_data = d;
        eng.px_transparent = t; eng.px_palettemode = p;
    endtask

    initial begin
        int cnt;
        bit seen;
        idle_inputs();
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        chk("rst_row", row, 0);
        chk("rst_clear", clear, 0);
        chk("rst_we", we, 0);
        chk("rst_px_ready", eng.px_ready, 0);
        chk("rst_target", eng.target_line, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1;
        step();

        // Line 5 -> 6, three pixels including the last visible column.
        ls(8'd5, 1'b0);
        chk("l5_clear", clear, 1);
        chk("l5_clear_row", row, 5);
        step();
        chk("l5_go", eng.render_go, 1);
        chk("l5_go_row", row, 6);
        chk("l5_target", eng.target_line, 6);
        step();
        pix(8'd0, 20'h12345, 1'b0, 1'b1); step();
        chk("l5_we0", we, 1);
        chk("l5_wcol0", wcol, 0);
        pix(8'd1, 20'hABCDE, 1'b1, 1'b0); step();
        pix(8'd239, 20'h0F0F0, 1'b0, 1'b0); step();
        eng.px_valid = 0;
        chk("l5_wcol239", wcol, 239);
        chk("l5_wdata239", wdata, 20'h0F0F0);
        eng.render_done = 1; step();
        eng.render_done = 0;
        chk("l5_we_idle", we, 0);
        repeat (3) step();

        // Wrap from the last line, then a line whose target is not visible.
        ls(8'd227, 1'b0);
        chk("wrap_target", eng.target_line, 0);
        chk("wrap_clear", clear, 1);
        chk("wrap_row", row, 227);
        repeat (3) step();
        eng.render_done = 1; step();
        eng.render_done = 0;
        step();
        ls(8'd159, 1'b0);
        chk("v159_target", eng.target_line, 160);
        chk("v159_clear", clear, 0);
        step();
        chk("v159_go", eng.render_go, 0);
        chk("v159_ready", eng.px_ready, 0);
        step();

        // H-blank-free budget expiry with the engine never finishing.
        ls(8'd20, 1'b1);
        cnt = 0; seen = 0;
        for (int i = 0; i < 1300 && !seen; i++) begin
            if (eng.px_ready === 1'b1) cnt++;
            if (overrun === 1'b1) seen = 1;
            else step();
        end
        chk("hbf_ready_cycles", cnt, 954);
        chk("hbf_overrun_seen", seen, 1);
        step();
        chk("hbf_overrun_pulse", overrun, 0);

        // Early line_start with a pixel accepted in the same cycle.
        ls(8'd30, 1'b0);
        repeat (4) step();
        chk("early_ready", eng.px_ready, 1);
        pix(8'd7, 20'h5A5A5, 1'b1, 1'b1);
        line_start = 1; vcount = 8'd40; hblank_free = 0;
        step();
        line_start = 0; eng.px_valid = 0;
        chk("early_we", we, 1);
        chk("early_wcol", wcol, 7);
        chk("early_overrun", overrun, 1);
        chk("early_clear", clear, 1);
        chk("early_row", row, 40);
        repeat (3) step();
        eng.render_done = 1; step();
        eng.render_done = 0;

        // render_done arriving exactly on the budget expiry cycle.
        ls(8'd50, 1'b1);
        for (int i = 0; i < 10 && eng.px_ready !== 1'b1; i++) step();
        for (int i = 0; i < 1300 && eng.px_ready === 1'b1; i++) step();
        eng.render_done = 1; step();
        eng.render_done = 0;
        chk("tie_overrun", overrun, 0);
        step();
        chk("tie_overrun_late", overrun, 0);

        // Reset in the middle of a render with a pixel being accepted.
        ls(8'd60, 1'b0);
        repeat (3) step();
        pix(8'd99, 20'hFFFFF, 1'b1, 1'b1); step();
        reset = 0; step();
        reset = 1; eng.px_valid = 0;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_clear", clear, 0);
        chk("mid_rst_ready", eng.px_ready, 0);
        chk("mid_rst_row", row, 0);
        step();

        // Randomized lines: normal finishes, budget expiries and early line_starts.
        for (int ln = 0; ln < 24; ln++) begin
            int mode, n;
            mode = $urandom_range(0, 3);
            n = (mode == 1) ? 1225 : (mode == 2) ? $urandom_range(1, 20) : $urandom_range(10, 80);
            ls(8'($urandom_range(0, 227)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < n; k++) begin
                eng.px_valid       = 1'($urandom_range(0, 1));
                eng.px_col         = 8'($urandom_range(0, 255));
                eng.px_data        = 20'($urandom);
                eng.px_transparent = 1'($urandom_range(0, 1));
                eng.px_palettemode = 1'($urandom_range(0, 1));
                eng.render_done    = (mode == 0 || mode == 3) && ($urandom_range(0, 15) == 0);
                step();
            end
            idle_inputs();
        end
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
